// File: rtl/curve_reg_bank.sv
// curve_reg_bank: I2C-facing register bank plus start/done/timeout controller for the Curve25519 core.
// Optional build macro CURVE_OPERAND_LOCK_EN rejects operand writes while an operation is in flight.
module curve_reg_bank #(
  parameter logic [7:0]  ID_VALUE       = 8'hC2,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   subaddr_7_0_in,
  input  logic [7:0]   wr_bus_7_0_in,
  input  logic         wr_pulse,
  output logic [7:0]   rd_bus_7_0_out,
  input  logic         rd_pulse,
  output logic         core_start,
  output logic [255:0] core_scalar,
  output logic [255:0] core_point,
  input  logic         core_done,
  input  logic [255:0] core_result,
  output logic         done_int
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  localparam logic [7:0]  ADDR_CTRL   = 8'h60;
  localparam logic [7:0]  ADDR_STATUS = 8'h61;
  localparam logic [7:0]  ADDR_ID     = 8'h62;
  localparam logic [23:0] TMO_LAST    = TIMEOUT_CYCLES - 24'd1;

  state_t        state;
  logic [23:0]   tmo_cnt;
  logic [255:0]  scalar_q;
  logic [255:0]  point_q;
  logic [255:0]  result_q;
  logic          int_en;
  logic          err_to;
  logic          err_wr;

  logic [7:0]    byte_sel;
  logic          wr_ctrl;
  logic          start_req;
  logic          status_ack;
  logic          operand_wr;
  logic          operand_wr_ok;
  logic          wr_scalar;
  logic          wr_point;
  logic [7:0]    status_byte;
  logic [7:0]    rd_next;

  // Bit offset of the addressed byte inside a 32-byte operand/result window.
  assign byte_sel    = {subaddr_7_0_in[4:0], 3'b000};

  assign wr_ctrl     = wr_pulse && (subaddr_7_0_in == ADDR_CTRL);
  assign start_req   = wr_ctrl && wr_bus_7_0_in[0] && (state != S_BUSY);
  assign status_ack  = rd_pulse && (subaddr_7_0_in == ADDR_STATUS);
  assign operand_wr  = wr_pulse && (subaddr_7_0_in[7:6] == 2'b00);

`ifdef CURVE_OPERAND_LOCK_EN
  assign operand_wr_ok = operand_wr && (state != S_BUSY);
`else
  assign operand_wr_ok = operand_wr;
`endif

  assign wr_scalar   = operand_wr_ok && !subaddr_7_0_in[5];
  assign wr_point    = operand_wr_ok &&  subaddr_7_0_in[5];

  assign status_byte = {4'b0000, err_wr, err_to, state == S_DONE, state == S_BUSY};

  assign core_scalar = scalar_q;
  assign core_point  = point_q;

  // NOTE: the operand bytes feed the core combinationally, so they are reset like
  // ordinary registers instead of being treated as uninitialised RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scalar_q <= '0;
      point_q  <= '0;
    end else begin
      if (wr_scalar) scalar_q[byte_sel +: 8] <= wr_bus_7_0_in;
      if (wr_point)  point_q[byte_sel +: 8]  <= wr_bus_7_0_in;
    end
  end

  always_comb begin
    // NOTE: default assignment first, so every path drives rd_next and no latch is inferred.
    rd_next = 8'h00;
    case (subaddr_7_0_in[7:5])
      3'b000:  rd_next = scalar_q[byte_sel +: 8];
      3'b001:  rd_next = point_q[byte_sel +: 8];
      3'b010:  rd_next = result_q[byte_sel +: 8];
      3'b011: begin
        case (subaddr_7_0_in)
          ADDR_CTRL:   rd_next = {6'b000000, int_en, 1'b0};
          ADDR_STATUS: rd_next = status_byte;
          ADDR_ID:     rd_next = ID_VALUE;
          default:     rd_next = 8'h00;
        endcase
      end
      default: rd_next = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_bus_7_0_out <= 8'h00;
    end else begin
      rd_bus_7_0_out <= rd_next;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      tmo_cnt    <= '0;
      core_start <= 1'b0;
      result_q   <= '0;
      int_en     <= 1'b0;
      err_to     <= 1'b0;
      err_wr     <= 1'b0;
      done_int   <= 1'b0;
    end else begin
      core_start <= 1'b0;
      done_int   <= (state == S_DONE) && int_en;
      if (wr_ctrl) int_en <= wr_bus_7_0_in[1];

      case (state)
        S_IDLE, S_DONE: begin
          if (start_req) begin
            state      <= S_BUSY;
            core_start <= 1'b1;
            tmo_cnt    <= '0;
            err_to     <= 1'b0;
            err_wr     <= 1'b0;
          end else if ((state == S_DONE) && status_ack) begin
            state <= S_IDLE;
          end
        end
        S_BUSY: begin
`ifdef CURVE_OPERAND_LOCK_EN
          if (operand_wr) err_wr <= 1'b1;
`endif
          // A completion landing on the timeout cycle takes priority over the abort.
          if (core_done) begin
            result_q <= core_result;
            state    <= S_DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            err_to <= 1'b1;
            state  <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 24'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_curve_reg_bank.sv
// tb_curve_reg_bank: directed plus randomized checks of curve_reg_bank against a byte-array reference model.
// Honors CURVE_OPERAND_LOCK_EN the same way as the design build.
module tb_curve_reg_bank;

  localparam logic [23:0] TMO = 24'd16;
`ifdef CURVE_OPERAND_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   subaddr;
  logic [7:0]   wr_bus;
  logic         wr_pulse;
  logic [7:0]   rd_bus;
  logic         rd_pulse;
  logic         core_start;
  logic [255:0] core_scalar;
  logic [255:0] core_point;
  logic         core_done;
  logic [255:0] core_result;
  logic         done_int;

  always #5 clk = ~clk;

  curve_reg_bank #(
    .ID_VALUE       (8'hC2),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .subaddr_7_0_in (subaddr),
    .wr_bus_7_0_in  (wr_bus),
    .wr_pulse       (wr_pulse),
    .rd_bus_7_0_out (rd_bus),
    .rd_pulse       (rd_pulse),
    .core_start     (core_start),
    .core_scalar    (core_scalar),
    .core_point     (core_point),
    .core_done      (core_done),
    .core_result    (core_result),
    .done_int       (done_int)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: the register map as byte arrays and the operation as a phase plus cycle count.
  typedef enum {PH_IDLE, PH_BUSY, PH_DONE} phase_t;
  byte unsigned m_scalar[32];
  byte unsigned m_point[32];
  byte unsigned m_result[32];
  bit           m_int_en;
  bit           m_err_to;
  bit           m_err_wr;
  phase_t       m_phase;
  int           m_busy_cycles;
  bit           m_start;
  bit           m_int;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_scalar[i] = 8'h00;
      m_point[i]  = 8'h00;
      m_result[i] = 8'h00;
    end
    m_int_en      = 1'b0;
    m_err_to      = 1'b0;
    m_err_wr      = 1'b0;
    m_phase       = PH_IDLE;
    m_busy_cycles = 0;
    m_start       = 1'b0;
    m_int         = 1'b0;
  endtask

  function automatic logic [255:0] pack(input byte unsigned arr[32]);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) v[8*i +: 8] = arr[i];
    return v;
  endfunction

  function automatic logic [7:0] model_read(input logic [7:0] a);
    if (a < 8'h20) return m_scalar[a];
    if (a < 8'h40) return m_point[a - 8'h20];
    if (a < 8'h60) return m_result[a - 8'h40];
    case (a)
      8'h60:   return {6'b000000, m_int_en, 1'b0};
      8'h61:   return {4'b0000, m_err_wr, m_err_to, m_phase == PH_DONE, m_phase == PH_BUSY};
      8'h62:   return 8'hC2;
      default: return 8'h00;
    endcase
  endfunction

  // One clock: drive at negedge, advance the model, compare just after the posedge.
  task automatic step(input logic [7:0] sa, input bit wr, input logic [7:0] d,
                      input bit rd, input bit cd, input logic [255:0] cr);
    logic [7:0] exp_rd;
    bit         launch;
    @(negedge clk);
    subaddr     = sa;
    wr_bus      = d;
    wr_pulse    = wr;
    rd_pulse    = rd;
    core_done   = cd;
    core_result = cr;

    exp_rd  = model_read(sa);
    m_int   = (m_phase == PH_DONE) && m_int_en;
    launch  = wr && (sa == 8'h60) && d[0] && (m_phase != PH_BUSY);
    m_start = launch;

    if (wr && (sa < 8'h40)) begin
      if (LOCK && (m_phase == PH_BUSY)) m_err_wr = 1'b1;
      else if (sa < 8'h20)              m_scalar[sa] = d;
      else                              m_point[sa - 8'h20] = d;
    end
    if (wr && (sa == 8'h60)) m_int_en = d[1];

    if (m_phase == PH_BUSY) begin
      m_busy_cycles++;
      if (cd) begin
        for (int i = 0; i < 32; i++) m_result[i] = cr[8*i +: 8];
        m_phase = PH_DONE;
      end else if (m_busy_cycles == int'(TMO)) begin
        m_err_to = 1'b1;
        m_phase  = PH_DONE;
      end
    end else if (launch) begin
      m_phase       = PH_BUSY;
      m_busy_cycles = 0;
      m_err_to      = 1'b0;
      m_err_wr      = 1'b0;
    end else if ((m_phase == PH_DONE) && rd && (sa == 8'h61)) begin
      m_phase = PH_IDLE;
    end

    @(posedge clk);
    #1;
    check("rd_bus", rd_bus, exp_rd);
    check("core_start", core_start, m_start);
    check("done_int", done_int, m_int);
    check("core_scalar", core_scalar, pack(m_scalar));
    check("core_point", core_point, pack(m_point));
  endtask

  task automatic idle(input logic [7:0] sa);
    step(sa, 1'b0, 8'h00, 1'b0, 1'b0, '0);
  endtask

  task automatic async_reset_check(input string tag);
    @(posedge clk);
    #2;
    wr_pulse  = 1'b0;
    rd_pulse  = 1'b0;
    core_done = 1'b0;
    reset     = 1'b0;
    #1;
    check({tag, "_rd_bus"}, rd_bus, 8'h00);
    check({tag, "_core_start"}, core_start, 1'b0);
    check({tag, "_done_int"}, done_int, 1'b0);
    check({tag, "_core_scalar"}, core_scalar, '0);
    check({tag, "_core_point"}, core_point, '0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [255:0] rnd;
    logic [7:0]   sa;
    bit           wr;
    bit           rd;
    bit           cd;
    int           sel;

    reset       = 1'b1;
    subaddr     = 8'h00;
    wr_bus      = 8'h00;
    wr_pulse    = 1'b0;
    rd_pulse    = 1'b0;
    core_done   = 1'b0;
    core_result = '0;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset state, asserted mid-cycle
    async_reset_check("rst0");
    idle(8'h62);
    check("id_read", rd_bus, 8'hC2);
    idle(8'h61);
    check("status_after_reset", rd_bus, 8'h00);

    // Operand round trip at both window ends
    step(8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, '0);
    step(8'h3F, 1'b1, 8'h5A, 1'b0, 1'b0, '0);
    idle(8'h00);
    check("rt_scalar_00", rd_bus, 8'hA5);
    idle(8'h3F);
    check("rt_point_3f", rd_bus, 8'h5A);
    check("scalar_lsb", core_scalar[7:0], 8'hA5);
    check("point_msb", core_point[255:248], 8'h5A);

    // Normal operation with interrupt enabled; second START while busy is ignored
    step(8'h60, 1'b1, 8'h03, 1'b0, 1'b0, '0);
    check("start_pulse", core_start, 1'b1);
    idle(8'h61);
    check("start_one_cycle", core_start, 1'b0);
    check("status_busy", rd_bus, 8'h01);
    step(8'h60, 1'b1, 8'h03, 1'b0, 1'b0, '0);
    check("no_second_start", core_start, 1'b0);
    step(8'h40, 1'b0, 8'h00, 1'b0, 1'b1, 256'h1234);
    idle(8'h40);
    check("result_40", rd_bus, 8'h34);
    idle(8'h41);
    check("result_41", rd_bus, 8'h12);
    idle(8'h61);
    check("status_done", rd_bus, 8'h02);
    check("done_int_set", done_int, 1'b1);
    step(8'h61, 1'b0, 8'h00, 1'b1, 1'b0, '0);
    idle(8'h61);
    check("done_int_clear", done_int, 1'b0);
    check("status_idle", rd_bus, 8'h00);

    // Timeout: exactly TMO cycles in BUSY, result bytes untouched
    step(8'h60, 1'b1, 8'h03, 1'b0, 1'b0, '0);
    for (int i = 0; i < int'(TMO); i++) begin
      idle(8'h61);
      check("timeout_busy", rd_bus, 8'h01);
    end
    idle(8'h61);
    check("timeout_status", rd_bus, 8'h06);
    idle(8'h40);
    check("timeout_result_40", rd_bus, 8'h34);
    idle(8'h41);
    check("timeout_result_41", rd_bus, 8'h12);
    check("timeout_done_int", done_int, 1'b1);
    step(8'h61, 1'b0, 8'h00, 1'b1, 1'b0, '0);

    // Operand write while BUSY
    step(8'h60, 1'b1, 8'h01, 1'b0, 1'b0, '0);
    step(8'h10, 1'b1, 8'h77, 1'b0, 1'b0, '0);
    idle(8'h10);
    check("busy_write_value", rd_bus, LOCK ? 8'h00 : 8'h77);
    idle(8'h61);
    check("busy_write_status", rd_bus, LOCK ? 8'h09 : 8'h01);
    step(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, {8{32'hDEADBEEF}});
    step(8'h61, 1'b0, 8'h00, 1'b1, 1'b0, '0);

    // Reset while BUSY, then a stray core_done in IDLE
    step(8'h60, 1'b1, 8'h01, 1'b0, 1'b0, '0);
    idle(8'h61);
    idle(8'h61);
    async_reset_check("rst_busy");
    step(8'h40, 1'b0, 8'h00, 1'b0, 1'b1, {8{32'hFFFFFFFF}});
    idle(8'h40);
    check("stray_done_result", rd_bus, 8'h00);
    idle(8'h61);
    check("stray_done_status", rd_bus, 8'h00);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: sa = 8'($urandom_range(0, 63));
        3:       sa = 8'($urandom_range(64, 95));
        4, 5:    sa = 8'h60;
        6, 7:    sa = 8'h61;
        8:       sa = 8'h62;
        default: sa = 8'($urandom_range(0, 255));
      endcase
      wr = ($urandom_range(0, 3) == 0);
      rd = (sa == 8'h61) && ($urandom_range(0, 1) == 1);
      cd = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < 8; k++) rnd[32*k +: 32] = $urandom;
      step(sa, wr, 8'($urandom_range(0, 255)), rd, cd, rnd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
